// File: rtl/pid_pwm_out.sv
// pid_pwm_out: signed PID control word -> sign/magnitude PWM for an H-bridge.
// Generates the per-period sample strobe, latches a new duty at each period
// wrap and inserts a dead-time gap (both legs off) on direction reversal.
module pid_pwm_out #(
    parameter int PERIOD = 1024,
    parameter int DEAD   = 8,
    parameter int CW     = $clog2(PERIOD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] control,
    input  logic               run,
    output logic               sample,
    output logic               pwm_a,
    output logic               pwm_b,
    output logic               dir,
    output logic               sat,
    output logic [CW-1:0]      cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEADT
    } state_t;

    localparam logic [CW-1:0] LAST    = CW'(PERIOD - 1);
    localparam logic [CW-1:0] DEAD_C  = CW'(DEAD);
    localparam logic [CW-1:0] PER_C   = CW'(PERIOD);
    localparam logic [16:0]   PER_17  = 17'(PERIOD);

    state_t        state, state_n;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] duty, duty_n;
    logic          dir_n, sat_n;
    logic          sample_n, pwm_a_n, pwm_b_n;
    logic [16:0]   ext, mag;
    logic          leg_on;

    // Next-state, next-count, duty latch and next output values.
    // Outputs are computed from the *next* state/count so the registered
    // pwm/sample line up with the cnt value shown in the same cycle.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        duty_n   = duty;
        dir_n    = dir;
        sat_n    = sat;
        sample_n = 1'b0;
        pwm_a_n  = 1'b0;
        pwm_b_n  = 1'b0;
        leg_on   = 1'b0;

        // 17-bit magnitude so that -32768 maps to +32768
        ext = {control[15], control};
        mag = control[15] ? (~ext + 17'd1) : ext;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (run) begin
                    state_n = RUN;
                    duty_n  = '0;
                end
            end
            default: begin
                if (!run) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = RUN;
                    sat_n   = (mag > PER_17);
                    duty_n  = (mag > PER_17) ? PER_C : mag[CW-1:0];
                    if ((mag != 17'd0) && (control[15] != dir)) begin
                        dir_n = control[15];
                        if (DEAD > 0) begin
                            state_n = DEADT;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    if ((state == DEADT) && (cnt_n >= DEAD_C)) begin
                        state_n = RUN;
                    end
                end
            end
        endcase

        sample_n = (state_n != IDLE) && (cnt_n == '0);
        leg_on   = (state_n == RUN) && (cnt_n < duty_n);
        pwm_a_n  = leg_on && !dir_n;
        pwm_b_n  = leg_on && dir_n;
    end

    // State, counter, duty and output flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            duty   <= '0;
            dir    <= 1'b0;
            sat    <= 1'b0;
            sample <= 1'b0;
            pwm_a  <= 1'b0;
            pwm_b  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            duty   <= duty_n;
            dir    <= dir_n;
            sat    <= sat_n;
            sample <= sample_n;
            pwm_a  <= pwm_a_n;
            pwm_b  <= pwm_b_n;
        end
    end

endmodule

// File: tb/tb_pid_pwm_out.sv
// Directed + scoreboarded bench for pid_pwm_out with PERIOD=16, DEAD=2.
module tb_pid_pwm_out;

    localparam int PERIOD = 16;
    localparam int DEAD   = 2;
    localparam int CW     = $clog2(PERIOD + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] control;
    logic               run;
    logic               sample, pwm_a, pwm_b, dir, sat;
    logic [CW-1:0]      cnt;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    logic [CW+4:0] obs, expv;

    pid_pwm_out #(.PERIOD(PERIOD), .DEAD(DEAD)) dut (
        .clk     (clk),
        .reset   (reset),
        .control (control),
        .run     (run),
        .sample  (sample),
        .pwm_a   (pwm_a),
        .pwm_b   (pwm_b),
        .dir     (dir),
        .sat     (sat),
        .cnt     (cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        run     = 1'b1;
        control = 16'sd5;
        step;
        step;
        obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
        expv = '0;
        total_cnt++;
        if (obs !== expv) $display("FAIL reset_state: got %b want %b", obs, expv);
        else pass_cnt++;
        reset = 1'b0;
        run   = 1'b0;
        step;
        obs = {sample, pwm_a, pwm_b, dir, sat, cnt};
        total_cnt++;
        if (obs !== expv) $display("FAIL reset_idle: got %b want %b", obs, expv);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        control = 16'sd5;
        run     = 1'b1;
        step;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < PERIOD; k++) begin
                obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
                expv = {(k == 0), (p == 1) && (k < 5), 1'b0, 1'b0, 1'b0, CW'(k)};
                total_cnt++;
                if (obs !== expv)
                    $display("FAIL basic p%0d k%0d: got %b want %b", p, k, obs, expv);
                else pass_cnt++;
                step;
            end
        end
    endtask

    // per-period table: control set at period start, then expected dir/sat and leg windows
    task automatic test_reversal;
        int ctl[3] = '{-6, -6, -6};
        int edr[3] = '{0, 1, 1};
        int alo[3] = '{0, 0, 0};
        int ahi[3] = '{5, 0, 0};
        int blo[3] = '{0, 2, 0};
        int bhi[3] = '{0, 6, 6};
        for (int p = 0; p < 3; p++) begin
            control = 16'(ctl[p]);
            for (int k = 0; k < PERIOD; k++) begin
                obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
                expv = {(k == 0), (k >= alo[p]) && (k < ahi[p]), (k >= blo[p]) && (k < bhi[p]),
                        edr[p][0], 1'b0, CW'(k)};
                total_cnt++;
                if (obs !== expv)
                    $display("FAIL reversal p%0d k%0d: got %b want %b", p, k, obs, expv);
                else pass_cnt++;
                step;
            end
        end
    endtask

    task automatic test_saturation;
        int ctl[5] = '{100, 100, -32768, 0, 0};
        int edr[5] = '{1, 0, 0, 1, 1};
        int esa[5] = '{0, 1, 1, 1, 0};
        int alo[5] = '{0, 2, 0, 0, 0};
        int ahi[5] = '{0, 16, 16, 0, 0};
        int blo[5] = '{0, 0, 0, 2, 0};
        int bhi[5] = '{6, 0, 0, 16, 0};
        for (int p = 0; p < 5; p++) begin
            control = 16'(ctl[p]);
            for (int k = 0; k < PERIOD; k++) begin
                obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
                expv = {(k == 0), (k >= alo[p]) && (k < ahi[p]), (k >= blo[p]) && (k < bhi[p]),
                        edr[p][0], esa[p][0], CW'(k)};
                total_cnt++;
                if (obs !== expv)
                    $display("FAIL saturation p%0d k%0d: got %b want %b", p, k, obs, expv);
                else pass_cnt++;
                step;
            end
        end
    endtask

    task automatic test_run_stop;
        // period with duty 0 (control 0 latched), queue -3 for the next one
        control = -16'sd3;
        for (int k = 0; k < PERIOD; k++) begin
            obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
            expv = {(k == 0), 1'b0, 1'b0, 1'b1, 1'b0, CW'(k)};
            total_cnt++;
            if (obs !== expv) $display("FAIL stop_pre k%0d: got %b want %b", k, obs, expv);
            else pass_cnt++;
            step;
        end
        for (int k = 0; k < 8; k++) begin
            obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
            expv = {(k == 0), 1'b0, (k < 3), 1'b1, 1'b0, CW'(k)};
            total_cnt++;
            if (obs !== expv) $display("FAIL stop_run k%0d: got %b want %b", k, obs, expv);
            else pass_cnt++;
            if (k < 7) step;
        end
        run = 1'b0;
        step;
        obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
        expv = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CW'(0)};
        total_cnt++;
        if (obs !== expv) $display("FAIL stop_idle: got %b want %b", obs, expv);
        else pass_cnt++;
        step;
        obs = {sample, pwm_a, pwm_b, dir, sat, cnt};
        total_cnt++;
        if (obs !== expv) $display("FAIL stop_hold: got %b want %b", obs, expv);
        else pass_cnt++;
        run = 1'b1;
        step;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < PERIOD; k++) begin
                obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
                expv = {(k == 0), 1'b0, (p == 1) && (k < 3), 1'b1, 1'b0, CW'(k)};
                total_cnt++;
                if (obs !== expv)
                    $display("FAIL restart p%0d k%0d: got %b want %b", p, k, obs, expv);
                else pass_cnt++;
                step;
            end
        end
    endtask

    task automatic test_reset_deadt;
        control = 16'sd4;
        for (int k = 0; k < PERIOD; k++) begin
            obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
            expv = {(k == 0), 1'b0, (k < 3), 1'b1, 1'b0, CW'(k)};
            total_cnt++;
            if (obs !== expv) $display("FAIL rdt_pre k%0d: got %b want %b", k, obs, expv);
            else pass_cnt++;
            step;
        end
        control = -16'sd4;
        for (int k = 0; k < PERIOD; k++) begin
            obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
            expv = {(k == 0), (k >= 2) && (k < 4), 1'b0, 1'b0, 1'b0, CW'(k)};
            total_cnt++;
            if (obs !== expv) $display("FAIL rdt_fwd k%0d: got %b want %b", k, obs, expv);
            else pass_cnt++;
            step;
        end
        for (int k = 0; k < 2; k++) begin
            obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
            expv = {(k == 0), 1'b0, 1'b0, 1'b1, 1'b0, CW'(k)};
            total_cnt++;
            if (obs !== expv) $display("FAIL rdt_dead k%0d: got %b want %b", k, obs, expv);
            else pass_cnt++;
            if (k == 0) step;
        end
        reset = 1'b1;
        step;
        obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
        expv = '0;
        total_cnt++;
        if (obs !== expv) $display("FAIL rdt_reset: got %b want %b", obs, expv);
        else pass_cnt++;
        // run still high: leaving IDLE shows cnt=0 with sample, not cnt=1
        reset = 1'b0;
        step;
        obs  = {sample, pwm_a, pwm_b, dir, sat, cnt};
        expv = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0)};
        total_cnt++;
        if (obs !== expv) $display("FAIL rdt_idle_exit: got %b want %b", obs, expv);
        else pass_cnt++;
        run = 1'b0;
        step;
    endtask

    task automatic test_random;
        int          m_duty = 0;
        bit          m_dir  = 1'b0;
        bit          m_sat  = 1'b0;
        bit          m_rev  = 1'b0;
        int          hi_a, hi_b, dead, eh, mag;
        logic signed [15:0] c;
        int unsigned r;
        control = 16'sd0;
        run     = 1'b1;
        step;
        for (int p = 0; p < 500; p++) begin
            r = $urandom_range(0, 3);
            if (r == 0)      c = 16'($urandom);
            else if (r == 1 && ($urandom_range(0, 9) == 0)) c = 16'sh8000;
            else             c = 16'($urandom_range(0, 40)) - 16'sd20;
            control = c;
            hi_a = 0;
            hi_b = 0;
            total_cnt++;
            if ({dir, sat} !== {m_dir, m_sat})
                $display("FAIL rand_dirsat p%0d: got %b%b want %b%b", p, dir, sat, m_dir, m_sat);
            else pass_cnt++;
            for (int k = 0; k < PERIOD; k++) begin
                total_cnt++;
                if (pwm_a && pwm_b) $display("FAIL rand_overlap p%0d k%0d: got 11 want not both", p, k);
                else pass_cnt++;
                hi_a += int'(pwm_a);
                hi_b += int'(pwm_b);
                step;
            end
            dead = m_rev ? DEAD : 0;
            eh   = (m_duty > dead) ? m_duty - dead : 0;
            total_cnt++;
            if (hi_a != (m_dir ? 0 : eh) || hi_b != (m_dir ? eh : 0))
                $display("FAIL rand_count p%0d: got a=%0d b=%0d want a=%0d b=%0d", p, hi_a, hi_b,
                         m_dir ? 0 : eh, m_dir ? eh : 0);
            else pass_cnt++;
            mag    = (c < 0) ? -int'(c) : int'(c);
            m_rev  = (mag != 0) && ((c < 0) != m_dir);
            if (m_rev) m_dir = (c < 0);
            m_sat  = (mag > PERIOD);
            m_duty = m_sat ? PERIOD : mag;
        end
    endtask

    initial begin
        reset   = 1'b1;
        run     = 1'b0;
        control = 16'sd0;
        test_reset;
        test_basic;
        test_reversal;
        test_saturation;
        test_run_stop;
        test_reset_deadt;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
